// File: rtl/ucode_sequencer.sv
// Micro-program sequencer: dispatches macro opcodes into microcode and steps a synchronous ROM.
// Define MSEQ_WATCHDOG_EN to add the per-instruction step watchdog and mpc-wrap error (seq_err).
module ucode_sequencer #(
  parameter int unsigned MINST_WIDTH = 44,
  parameter int unsigned MPC_WIDTH   = 8,
  parameter int unsigned OPC_WIDTH   = 5,
  parameter int unsigned WDOG_LIMIT  = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [OPC_WIDTH-1:0]   inst_type,
  output logic                   rom_en,
  output logic [MPC_WIDTH-1:0]   rom_addr,
  input  logic [MINST_WIDTH-1:0] rom_rdata,
  output logic [MINST_WIDTH-1:0] minstr_out,
  output logic                   minstr_valid,
  input  logic                   is_branch_md,
  input  logic [MPC_WIDTH-1:0]   mbranch_target_md,
  input  logic                   cond_flag,
  input  logic                   stall,
  output logic                   instr_done,
  output logic                   seq_err
);

  typedef enum logic [1:0] {StIdle, StFetch, StExec} state_e;

  localparam logic [2:0] MtEnd = 3'b111;
  localparam logic [2:0] MtBr  = 3'b100;
  localparam logic [2:0] MtCbr = 3'b011;

  state_e               r_state, w_state_nxt;
  logic [MPC_WIDTH-1:0] r_mpc, w_mpc_nxt, w_mpc_inc, w_dispatch_pc;
  logic [2:0]           w_mt;
  logic                 w_advance, w_end, w_take_br, w_wrap, w_wdog_trip;

  assign w_mt          = rom_rdata[MINST_WIDTH-1 -: 3];
  assign w_end         = (w_mt == MtEnd);
  // The micro-op type field alone decides branching; decoder's is_branch_md is advisory only.
  assign w_take_br     = (w_mt == MtBr) || ((w_mt == MtCbr) && cond_flag);
  assign w_mpc_inc     = r_mpc + 1'b1;
  assign w_dispatch_pc = MPC_WIDTH'({inst_type, 3'b000});
  assign w_advance     = (r_state == StExec) && !stall;
  assign w_wrap        = w_advance && !w_end && !w_take_br && (r_mpc == '1);
  assign rom_addr      = r_mpc;

`ifdef MSEQ_WATCHDOG_EN
  localparam int unsigned StepW = $clog2(WDOG_LIMIT + 1);

  logic [StepW-1:0] r_steps, w_steps_inc;
  logic             r_seq_err;
  logic             w_unused_sig;

  assign w_steps_inc  = r_steps + 1'b1;
  assign w_wdog_trip  = w_advance && !w_end && (32'(w_steps_inc) >= WDOG_LIMIT);
  assign seq_err      = r_seq_err;
  assign w_unused_sig = is_branch_md;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_steps   <= '0;
      r_seq_err <= 1'b0;
    end else begin
      if ((r_state == StIdle) && instr_valid) begin
        r_steps <= '0;
      end else if (w_advance) begin
        r_steps <= w_steps_inc;
      end
      if (w_wdog_trip || w_wrap) begin
        r_seq_err <= 1'b1;
      end
    end
  end
`else
  logic w_unused_sig;

  assign w_wdog_trip  = 1'b0;
  assign seq_err      = 1'b0;
  assign w_unused_sig = ^{is_branch_md, w_wrap, 32'(WDOG_LIMIT)};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_mpc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mpc   <= w_mpc_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mpc_nxt    = r_mpc;
    instr_ready  = 1'b0;
    rom_en       = 1'b0;
    minstr_valid = 1'b0;
    minstr_out   = '0;
    instr_done   = 1'b0;
    unique case (r_state)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_mpc_nxt   = w_dispatch_pc;
          w_state_nxt = StFetch;
        end
      end
      StFetch: begin
        rom_en      = 1'b1;
        w_state_nxt = StExec;
      end
      StExec: begin
        minstr_valid = 1'b1;
        minstr_out   = rom_rdata;
        if (!stall) begin
          if (w_end) begin
            instr_done  = 1'b1;
            w_state_nxt = StIdle;
          end else if (w_wdog_trip) begin
            w_state_nxt = StIdle;
          end else begin
            w_state_nxt = StFetch;
            w_mpc_nxt   = w_take_br ? mbranch_target_md : w_mpc_inc;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

endmodule

// File: tb/tb_ucode_sequencer.sv
// Self-checking bench for ucode_sequencer: directed scenarios plus random microprograms
// checked cycle by cycle against a step-level program-walk model.
`timescale 1ns/1ps
module tb_ucode_sequencer;

  localparam int unsigned MW   = 44;
  localparam int unsigned PW   = 8;
  localparam int unsigned OW   = 5;
  localparam int unsigned WDOG = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [OW-1:0] inst_type = '0;
  logic          rom_en;
  logic [PW-1:0] rom_addr;
  logic [MW-1:0] rom_rdata = '0;
  logic [MW-1:0] minstr_out;
  logic          minstr_valid;
  logic          is_branch_md = 1'b0;
  logic [PW-1:0] mbranch_target_md;
  logic          cond_flag = 1'b0;
  logic          stall = 1'b0;
  logic          instr_done;
  logic          seq_err;

  logic [MW-1:0] rom [256];
  int            n_run = 0;
  int            n_fail = 0;
  logic          exp_err = 1'b0;

  ucode_sequencer #(
    .MINST_WIDTH(MW),
    .MPC_WIDTH  (PW),
    .OPC_WIDTH  (OW),
    .WDOG_LIMIT (WDOG)
  ) u_dut (
    .clk              (clk),
    .rst              (rst),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .inst_type        (inst_type),
    .rom_en           (rom_en),
    .rom_addr         (rom_addr),
    .rom_rdata        (rom_rdata),
    .minstr_out       (minstr_out),
    .minstr_valid     (minstr_valid),
    .is_branch_md     (is_branch_md),
    .mbranch_target_md(mbranch_target_md),
    .cond_flag        (cond_flag),
    .stall            (stall),
    .instr_done       (instr_done),
    .seq_err          (seq_err)
  );

  always #5 clk = ~clk;

  // Synchronous ROM and the decoder's target field (low byte of the micro-instruction).
  always_ff @(posedge clk) if (rom_en) rom_rdata <= rom[rom_addr];
  assign mbranch_target_md = rom_rdata[PW-1:0];

  function automatic logic [MW-1:0] mi(input logic [2:0] mt, input logic [7:0] tgt);
    logic [MW-1:0] w;
    w = MW'({$urandom, $urandom});
    w[MW-1 -: 3] = mt;
    w[7:0] = tgt;
    return w;
  endfunction

  // Walks the microprogram step by step, checking every cycle; returns cycles from accept to IDLE.
  task automatic run_instr(input logic [4:0] op, input int stall_first, input int stall_pct,
                           input int cond_mode, input int max_steps,
                           output int cycles, output bit fin, output bit ended);
    logic [7:0] pc;
    logic [7:0] tgt;
    logic [2:0] mt;
    bit st, cf;
    int steps, nst;
    cycles = 0; fin = 0; ended = 0; steps = 0; nst = stall_first;
    stall = 1'b0; instr_valid = 1'b1; inst_type = op;
    #1;
    n_run++;
    if ({instr_ready, rom_en, minstr_valid, instr_done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL idle_accept: got %b want 1000",
               {instr_ready, rom_en, minstr_valid, instr_done});
    end
    @(negedge clk);
    cycles = 1;
    pc = {op, 3'b000};
    while (!fin && steps < max_steps) begin
      instr_valid = 1'($urandom);
      inst_type = 5'($urandom);
      #1;
      n_run++;
      if ({instr_ready, rom_en, rom_addr, minstr_valid, minstr_out, instr_done, seq_err} !==
          {1'b0, 1'b1, pc, 1'b0, MW'(0), 1'b0, exp_err}) begin
        n_fail++;
        $display("FAIL fetch pc=%h: got rdy=%b en=%b addr=%h mv=%b mo=%h done=%b err=%b, want addr=%h en=1 err=%b",
                 pc, instr_ready, rom_en, rom_addr, minstr_valid, minstr_out, instr_done, seq_err,
                 pc, exp_err);
      end
      @(negedge clk);
      cycles++;
      do begin
        st = (nst > 0) ? 1'b1 : ($urandom_range(99) < stall_pct);
        if (nst > 0) nst--;
        cf = (cond_mode == 2) ? 1'($urandom) : (cond_mode == 1);
        stall = st; cond_flag = cf; is_branch_md = 1'($urandom);
        mt = rom[pc][MW-1 -: 3];
        tgt = rom[pc][7:0];
        #1;
        n_run++;
        if ({instr_ready, rom_en, rom_addr, minstr_valid, minstr_out, instr_done, seq_err} !==
            {1'b0, 1'b0, pc, 1'b1, rom[pc], (!st && mt == 3'b111), exp_err}) begin
          n_fail++;
          $display("FAIL exec pc=%h stall=%b: got rdy=%b en=%b addr=%h mv=%b mo=%h done=%b err=%b, want mo=%h done=%b err=%b",
                   pc, st, instr_ready, rom_en, rom_addr, minstr_valid, minstr_out, instr_done,
                   seq_err, rom[pc], (!st && mt == 3'b111), exp_err);
        end
        if (!st) begin
          steps++;
          if (mt == 3'b111) begin
            fin = 1; ended = 1;
          end else if (mt == 3'b100 || (mt == 3'b011 && cf)) begin
            pc = tgt;
          end else begin
`ifdef MSEQ_WATCHDOG_EN
            if (pc == 8'hFF) exp_err = 1'b1;
`endif
            pc = pc + 8'd1;
          end
`ifdef MSEQ_WATCHDOG_EN
          if (!fin && steps >= int'(WDOG)) begin
            fin = 1; exp_err = 1'b1;
          end
`endif
        end
        @(negedge clk);
        cycles++;
      end while (st);
    end
    stall = 1'b0; instr_valid = 1'b0;
    if (fin) begin
      #1;
      n_run++;
      if ({instr_ready, rom_en, minstr_valid, instr_done, seq_err} !== {4'b1000, exp_err}) begin
        n_fail++;
        $display("FAIL idle_return: got %b want %b",
                 {instr_ready, rom_en, minstr_valid, instr_done, seq_err}, {4'b1000, exp_err});
      end
    end
  endtask

  task automatic check_cycles(input string name, input int got, input int want);
    n_run++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s cycles: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
  endtask

  // Called with the DUT in FETCH; moves into EXEC and asserts reset there.
  task automatic abort_with_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    exp_err = 1'b0;
    n_run++;
    if ({instr_ready, rom_en, rom_addr, minstr_valid, minstr_out, instr_done, seq_err} !==
        {1'b1, 1'b0, 8'h00, 1'b0, MW'(0), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_exec: got rdy=%b en=%b addr=%h mv=%b mo=%h done=%b err=%b want 1 0 00 0 0 0 0",
               instr_ready, rom_en, rom_addr, minstr_valid, minstr_out, instr_done, seq_err);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_run++;
    if ({instr_ready, rom_en, minstr_valid, instr_done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 1000",
               {instr_ready, rom_en, minstr_valid, instr_done});
    end
  endtask

  task automatic test_reset();
    #2;
    n_run++;
    if ({instr_ready, rom_en, rom_addr, minstr_valid, minstr_out, instr_done, seq_err} !==
        {1'b1, 1'b0, 8'h00, 1'b0, MW'(0), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%b en=%b addr=%h mv=%b mo=%h done=%b err=%b want 1 0 00 0 0 0 0",
               instr_ready, rom_en, rom_addr, minstr_valid, minstr_out, instr_done, seq_err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_dispatch_end();
    int cyc; bit fin, ended;
    rom[8'h18] = mi(3'b111, 8'h00);
    run_instr(5'd3, 0, 0, 0, 16, cyc, fin, ended);
    check_cycles("dispatch_end", cyc, 3);
  endtask

  task automatic test_sequential();
    int cyc; bit fin, ended;
    rom[8'h18] = mi(3'b000, 8'h77);
    rom[8'h19] = mi(3'b101, 8'h66);
    rom[8'h1A] = mi(3'b111, 8'h00);
    run_instr(5'd3, 0, 0, 0, 16, cyc, fin, ended);
    check_cycles("sequential", cyc, 7);
  endtask

  task automatic test_branches();
    int cyc; bit fin, ended;
    rom[8'h09] = mi(3'b111, 8'h00);
    rom[8'h40] = mi(3'b111, 8'h00);
    rom[8'h08] = mi(3'b100, 8'h40);
    run_instr(5'd1, 0, 0, 0, 16, cyc, fin, ended);
    check_cycles("branch_uncond", cyc, 5);
    rom[8'h08] = mi(3'b011, 8'h40);
    run_instr(5'd1, 0, 0, 0, 16, cyc, fin, ended);
    check_cycles("branch_cond0", cyc, 5);
    run_instr(5'd1, 0, 0, 1, 16, cyc, fin, ended);
    check_cycles("branch_cond1", cyc, 5);
  endtask

  task automatic test_stall();
    int cyc; bit fin, ended;
    rom[8'h18] = mi(3'b010, 8'h55);
    rom[8'h19] = mi(3'b111, 8'h00);
    run_instr(5'd3, 3, 0, 0, 16, cyc, fin, ended);
    check_cycles("stall", cyc, 8);
  endtask

  task automatic test_wrap();
    int cyc; bit fin, ended;
    logic want;
`ifdef MSEQ_WATCHDOG_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    rom[8'hF8] = mi(3'b100, 8'hFF);
    rom[8'hFF] = mi(3'b001, 8'h12);
    rom[8'h00] = mi(3'b111, 8'h00);
    run_instr(5'd31, 0, 0, 0, 16, cyc, fin, ended);
    check_cycles("wrap", cyc, 7);
    n_run++;
    if (seq_err !== want) begin
      n_fail++;
      $display("FAIL wrap_seq_err: got %b want %b", seq_err, want);
    end
    reset_pulse();
  endtask

  task automatic test_watchdog();
    int cyc; bit fin, ended;
    rom[8'h10] = mi(3'b100, 8'h10);
    run_instr(5'd2, 0, 0, 0, 6, cyc, fin, ended);
`ifdef MSEQ_WATCHDOG_EN
    check_cycles("watchdog", cyc, 9);
    n_run++;
    if ({fin, ended, seq_err} !== 3'b101) begin
      n_fail++;
      $display("FAIL watchdog_trip: got fin/end/err=%b%b%b want 101", fin, ended, seq_err);
    end
`else
    n_run++;
    if ({fin, seq_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL no_watchdog: got fin/err=%b%b want 00", fin, seq_err);
    end
    abort_with_reset();
`endif
  endtask

  task automatic test_reset_mid();
    int cyc; bit fin, ended;
    rom[8'h10] = mi(3'b100, 8'h10);
    run_instr(5'd2, 0, 0, 0, 2, cyc, fin, ended);
    abort_with_reset();
  endtask

  task automatic test_random();
    int cyc; bit fin, ended;
    logic [4:0] op;
    logic [7:0] base;
    for (int it = 0; it < 30; it++) begin
      op = 5'($urandom);
      base = {op, 3'b000};
      for (int s = 0; s < 8; s++) begin
        if (s == 7) rom[base + 8'(s)] = mi(3'b111, 8'($urandom));
        else rom[base + 8'(s)] = mi(3'($urandom),
                                    base + 8'(s + 1) + 8'($urandom_range(6 - s)));
      end
      run_instr(op, 0, int'($urandom_range(40)), 2, 16, cyc, fin, ended);
      n_run++;
      if (!fin) begin
        n_fail++;
        $display("FAIL random_terminate op=%0d: got fin=%b want 1", op, fin);
      end
      if (exp_err) reset_pulse();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = mi(3'b111, 8'h00);
    test_reset();
    test_dispatch_end();
    test_sequential();
    test_branches();
    test_stall();
    test_wrap();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
